// File: rtl/prog_ram_if.sv
// Bus bundle between the 4-bit computer and its program/data RAM.
// The bundle carries the load port, the run-mode access port and the status outputs.
interface prog_ram_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              prog_mode;
   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_done;
   logic [ADDR_W-1:0] addr;
   logic              rd_en;
   logic              wr_en;
   logic [DATA_W-1:0] dIn;
   logic [DATA_W-1:0] dOut;
   logic              dValid;
   logic              busy;

   modport master (
      output prog_mode, ld_valid, ld_addr, ld_data, addr, rd_en, wr_en, dIn,
      input  ld_ready, ld_done, dOut, dValid, busy
   );

   modport slave (
      input  prog_mode, ld_valid, ld_addr, ld_data, addr, rd_en, wr_en, dIn,
      output ld_ready, ld_done, dOut, dValid, busy
   );
endinterface

// File: rtl/prog_ram.sv
// 16 x 8 program/data RAM: clears itself after reset, then serves the load port or run-mode accesses.
// Run-mode reads have one cycle of latency and return the old word on a same-cycle write.
module prog_ram #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   prog_ram_if.slave      bus
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t            state_reg;
   logic [ADDR_W-1:0] clr_cnt_reg;
   logic [DATA_W-1:0] dout_reg;
   logic              dvalid_reg;
   logic              ld_done_reg;
   logic              busy_reg;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              ld_fire;

   assign bus.ld_ready = (state_reg == ST_LOAD);
   assign ld_fire      = bus.ld_valid && (state_reg == ST_LOAD);

   // One shared write port; the active state decides who owns it.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_cnt_reg;
      mem_wdata = '0;
      case (state_reg)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_reg;
            mem_wdata = '0;
         end
         ST_LOAD: begin
            mem_we    = bus.ld_valid;
            mem_waddr = bus.ld_addr;
            mem_wdata = bus.ld_data;
         end
         ST_RUN: begin
            mem_we    = bus.wr_en;
            mem_waddr = bus.addr;
            mem_wdata = bus.dIn;
         end
         default: begin
            mem_we = 1'b0;
         end
      endcase
      if (rst) begin
         mem_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_CLEAR;
         clr_cnt_reg <= '0;
         dout_reg    <= '0;
         dvalid_reg  <= 1'b0;
         ld_done_reg <= 1'b0;
         busy_reg    <= 1'b1;
      end else begin
         dvalid_reg  <= 1'b0;
         ld_done_reg <= 1'b0;
         case (state_reg)
            ST_CLEAR: begin
               clr_cnt_reg <= clr_cnt_reg + 1'b1;
               if (clr_cnt_reg == ADDR_MAX) begin
                  busy_reg  <= 1'b0;
                  state_reg <= bus.prog_mode ? ST_LOAD : ST_RUN;
               end
            end
            ST_LOAD: begin
               if (ld_fire && (bus.ld_addr == ADDR_MAX)) begin
                  ld_done_reg <= 1'b1;
               end
               if (!bus.prog_mode) begin
                  state_reg <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Read sees the array before this edge's write lands.
               if (bus.rd_en) begin
                  dout_reg   <= mem[bus.addr];
                  dvalid_reg <= 1'b1;
               end
               if (bus.prog_mode) begin
                  state_reg <= ST_LOAD;
               end
            end
            default: begin
               state_reg <= ST_CLEAR;
            end
         endcase
      end
   end

   assign bus.dOut    = dout_reg;
   assign bus.dValid  = dvalid_reg;
   assign bus.ld_done = ld_done_reg;
   assign bus.busy    = busy_reg;
endmodule

// File: tb/tb_prog_ram.sv
// Randomised self-checking bench for prog_ram against an array model of the 16-word memory.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_prog_ram;
   localparam int AW = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   prog_ram_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   prog_ram #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] model_mem [16];
   logic [7:0] last_dout;
   int checks = 0;
   int errors = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ld_valid = 1'b0;
      bus.ld_addr  = '0;
      bus.ld_data  = '0;
      bus.rd_en    = 1'b0;
      bus.wr_en    = 1'b0;
      bus.addr     = '0;
      bus.dIn      = '0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      idle_inputs();
      bus.prog_mode = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
      last_dout = 8'h00;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (bus.dOut !== 8'h00) begin errors++; $display("FAIL reset_dout got %h expected 00", bus.dOut); end
      checks++; if (bus.dValid !== 1'b0) begin errors++; $display("FAIL reset_dvalid got %b expected 0", bus.dValid); end
      checks++; if (bus.ld_done !== 1'b0) begin errors++; $display("FAIL reset_ld_done got %b expected 0", bus.ld_done); end
      for (int i = 0; i < 16; i++) begin
         checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL clear_busy cycle %0d got %b expected 1", i, bus.busy); end
         checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL clear_ld_ready cycle %0d got %b expected 0", i, bus.ld_ready); end
         tick();
      end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clear_busy_end got %b expected 0", bus.busy); end
      for (int i = 0; i < 16; i++) begin
         bus.addr  = 4'(i);
         bus.rd_en = 1'b1;
         tick();
         checks++; if (bus.dValid !== 1'b1 || bus.dOut !== model_mem[i]) begin errors++; $display("FAIL clear_read addr %0d got %b/%h expected 1/%h", i, bus.dValid, bus.dOut, model_mem[i]); end
         last_dout = model_mem[i];
      end
      bus.rd_en = 1'b0;
      tick();
      checks++; if (bus.dValid !== 1'b0 || bus.dOut !== last_dout) begin errors++; $display("FAIL read_hold got %b/%h expected 0/%h", bus.dValid, bus.dOut, last_dout); end
      $display("test_reset done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_load();
      logic [3:0] la [3];
      logic [7:0] lv [3];
      logic [3:0] ra [4];
      int done_count;
      la = '{4'd6, 4'd15, 4'd3};
      lv = '{8'hA5, 8'h3C, 8'h81};
      ra = '{4'd6, 4'd15, 4'd3, 4'd9};
      done_count = 0;
      bus.prog_mode = 1'b1;
      tick();
      checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b expected 1", bus.ld_ready); end
      for (int k = 0; k < 3; k++) begin
         bus.ld_valid = 1'b1;
         bus.ld_addr  = la[k];
         bus.ld_data  = lv[k];
         tick();
         model_mem[la[k]] = lv[k];
         if (bus.ld_done === 1'b1) done_count++;
         checks++; if (bus.ld_done !== (la[k] == 4'd15)) begin errors++; $display("FAIL load_done addr %0d got %b expected %b", la[k], bus.ld_done, (la[k] == 4'd15)); end
         $display("load addr=%0d data=%h ld_done=%b", la[k], lv[k], bus.ld_done);
      end
      bus.ld_valid = 1'b0;
      tick();
      checks++; if (bus.ld_done !== 1'b0) begin errors++; $display("FAIL load_done_after got %b expected 0", bus.ld_done); end
      checks++; if (done_count !== 1) begin errors++; $display("FAIL load_done_count got %0d expected 1", done_count); end
      bus.prog_mode = 1'b0;
      tick();
      checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL run_ready got %b expected 0", bus.ld_ready); end
      for (int k = 0; k < 4; k++) begin
         bus.addr  = ra[k];
         bus.rd_en = 1'b1;
         tick();
         checks++; if (bus.dValid !== 1'b1 || bus.dOut !== model_mem[ra[k]]) begin errors++; $display("FAIL load_readback addr %0d got %b/%h expected 1/%h", ra[k], bus.dValid, bus.dOut, model_mem[ra[k]]); end
         last_dout = model_mem[ra[k]];
         $display("read addr=%0d dOut=%h", ra[k], bus.dOut);
      end
      bus.rd_en = 1'b0;
   endtask

   task automatic test_rw_same();
      logic [7:0] expv;
      expv = model_mem[14];
      bus.addr  = 4'd14;
      bus.dIn   = 8'h7E;
      bus.wr_en = 1'b1;
      bus.rd_en = 1'b1;
      tick();
      checks++; if (bus.dOut !== expv) begin errors++; $display("FAIL rw_old got %h expected %h", bus.dOut, expv); end
      model_mem[14] = 8'h7E;
      bus.wr_en = 1'b0;
      tick();
      checks++; if (bus.dOut !== model_mem[14]) begin errors++; $display("FAIL rw_new got %h expected %h", bus.dOut, model_mem[14]); end
      last_dout = model_mem[14];
      bus.rd_en = 1'b0;
      $display("rw_same addr=14 old=%h new=%h", expv, model_mem[14]);
   endtask

   task automatic test_load_idle();
      bus.prog_mode = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         bus.ld_valid = 1'b0;
         bus.rd_en    = 1'b1;
         bus.wr_en    = 1'b1;
         bus.addr     = 4'd2;
         bus.dIn      = 8'hFF;
         tick();
         checks++; if (bus.dValid !== 1'b0 || bus.dOut !== last_dout) begin errors++; $display("FAIL load_idle_read got %b/%h expected 0/%h", bus.dValid, bus.dOut, last_dout); end
         checks++; if (bus.ld_done !== 1'b0) begin errors++; $display("FAIL load_idle_done got %b expected 0", bus.ld_done); end
      end
      bus.rd_en    = 1'b0;
      bus.wr_en    = 1'b0;
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 4'd2;
      bus.ld_data  = 8'h11;
      tick();
      model_mem[2] = 8'h11;
      bus.ld_valid  = 1'b0;
      bus.prog_mode = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         bus.addr  = 4'(i);
         bus.rd_en = 1'b1;
         tick();
         checks++; if (bus.dValid !== 1'b1 || bus.dOut !== model_mem[i]) begin errors++; $display("FAIL idle_readback addr %0d got %b/%h expected 1/%h", i, bus.dValid, bus.dOut, model_mem[i]); end
         last_dout = model_mem[i];
      end
      bus.rd_en = 1'b0;
      $display("test_load_idle done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_mode_switch_read();
      logic [7:0] v;
      v = 8'($urandom_range(255));
      bus.addr  = 4'd9;
      bus.dIn   = v;
      bus.wr_en = 1'b1;
      tick();
      model_mem[9] = v;
      bus.wr_en     = 1'b0;
      bus.rd_en     = 1'b1;
      bus.prog_mode = 1'b1;
      tick();
      checks++; if (bus.dValid !== 1'b1 || bus.dOut !== model_mem[9]) begin errors++; $display("FAIL switch_read got %b/%h expected 1/%h", bus.dValid, bus.dOut, model_mem[9]); end
      checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL switch_ready got %b expected 1", bus.ld_ready); end
      last_dout = model_mem[9];
      bus.rd_en = 1'b0;
      tick();
      checks++; if (bus.dValid !== 1'b0 || bus.ld_ready !== 1'b1) begin errors++; $display("FAIL switch_after got %b/%b expected 0/1", bus.dValid, bus.ld_ready); end
      bus.prog_mode = 1'b0;
      tick();
      checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL switch_back_ready got %b expected 0", bus.ld_ready); end
      $display("mode_switch read addr=9 dOut=%h", last_dout);
   endtask

   task automatic test_random();
      logic rd, wr, v;
      logic [3:0] a;
      logic [7:0] d, expv;
      for (int i = 0; i < 200; i++) begin
         rd = 1'($urandom_range(1));
         wr = 1'($urandom_range(1));
         a  = 4'($urandom_range(15));
         d  = 8'($urandom_range(255));
         expv = model_mem[a];
         bus.rd_en = rd;
         bus.wr_en = wr;
         bus.addr  = a;
         bus.dIn   = d;
         tick();
         if (rd) begin
            checks++; if (bus.dValid !== 1'b1 || bus.dOut !== expv) begin errors++; $display("FAIL rand_read %0d addr %0d got %b/%h expected 1/%h", i, a, bus.dValid, bus.dOut, expv); end
            last_dout = expv;
         end else begin
            checks++; if (bus.dValid !== 1'b0 || bus.dOut !== last_dout) begin errors++; $display("FAIL rand_idle %0d got %b/%h expected 0/%h", i, bus.dValid, bus.dOut, last_dout); end
         end
         if (wr) model_mem[a] = d;
      end
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      bus.prog_mode = 1'b1;
      tick();
      for (int i = 0; i < 40; i++) begin
         v = 1'($urandom_range(1));
         a = 4'($urandom_range(15));
         d = 8'($urandom_range(255));
         bus.ld_valid = v;
         bus.ld_addr  = a;
         bus.ld_data  = d;
         tick();
         checks++; if (bus.ld_done !== (v && a == 4'd15)) begin errors++; $display("FAIL rand_ld_done %0d got %b expected %b", i, bus.ld_done, (v && a == 4'd15)); end
         if (v) model_mem[a] = d;
      end
      bus.ld_valid  = 1'b0;
      bus.prog_mode = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         bus.addr  = 4'(i);
         bus.rd_en = 1'b1;
         tick();
         checks++; if (bus.dValid !== 1'b1 || bus.dOut !== model_mem[i]) begin errors++; $display("FAIL rand_readback addr %0d got %b/%h expected 1/%h", i, bus.dValid, bus.dOut, model_mem[i]); end
         last_dout = model_mem[i];
      end
      bus.rd_en = 1'b0;
      $display("test_random done: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_reset_mid_clear();
      bus.prog_mode = 1'b1;
      tick();
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 4'd5;
      bus.ld_data  = 8'h55;
      tick();
      bus.ld_valid  = 1'b0;
      bus.prog_mode = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midclear_busy_pre cycle %0d got %b expected 1", i, bus.busy); end
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
      last_dout = 8'h00;
      checks++; if (bus.dOut !== 8'h00) begin errors++; $display("FAIL midclear_dout got %h expected 00", bus.dOut); end
      for (int i = 0; i < 16; i++) begin
         checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midclear_busy cycle %0d got %b expected 1", i, bus.busy); end
         tick();
      end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midclear_busy_end got %b expected 0", bus.busy); end
      bus.addr  = 4'd5;
      bus.rd_en = 1'b1;
      tick();
      checks++; if (bus.dValid !== 1'b1 || bus.dOut !== model_mem[5]) begin errors++; $display("FAIL midclear_read5 got %b/%h expected 1/%h", bus.dValid, bus.dOut, model_mem[5]); end
      bus.rd_en = 1'b0;
      $display("reset_mid_clear read addr=5 dOut=%h", bus.dOut);
   endtask

   initial begin
      rst = 1'b1;
      bus.prog_mode = 1'b0;
      idle_inputs();
      test_reset();
      test_load();
      test_rw_same();
      test_load_idle();
      test_mode_switch_read();
      test_random();
      test_reset_mid_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
